// File: rtl/ball_engine_if.sv
// Signal bundle between the Pong ball engine and the paddles, renderer and score display.
interface ball_engine_if;
    logic       start;
    logic [9:0] p1_ypos;
    logic [9:0] p2_ypos;
    logic [9:0] sq_xpos;
    logic [9:0] sq_ypos;
    logic       sq_xveldir;
    logic       sq_yveldir;
    logic       sq_missed;
    logic       reset_game;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic       game_over;

    modport master (
        output start, p1_ypos, p2_ypos,
        input  sq_xpos, sq_ypos, sq_xveldir, sq_yveldir, sq_missed,
               reset_game, score_p1, score_p2, game_over
    );

    modport slave (
        input  start, p1_ypos, p2_ypos,
        output sq_xpos, sq_ypos, sq_xveldir, sq_yveldir, sq_missed,
               reset_game, score_p1, score_p2, game_over
    );
endinterface

// File: rtl/ball_engine.sv
// Pong ball physics and scoring: moves the square, bounces it off walls and paddles,
// detects misses, keeps both scores and sequences serve / miss / game-over.
module ball_engine #(
    parameter int CLK_HZ     = 25_175_000,
    parameter int H_VIDEO    = 640,
    parameter int V_VIDEO    = 480,
    parameter int SQ_WIDTH   = 16,
    parameter int PDL_HEIGHT = 96,
    parameter int PDL_WIDTH  = 8,
    parameter int P1_X       = 16,
    parameter int P2_X       = 616,
    parameter int SPEED      = 300,
    parameter int MISS_MS    = 1000,
    parameter int SERVE_MS   = 500,
    parameter int WIN_SCORE  = 9
) (
    input  logic         clk_0,
    input  logic         rst,
    ball_engine_if.slave bus
);
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SERVE     = 3'd1;
    localparam logic [2:0] ST_PLAY      = 3'd2;
    localparam logic [2:0] ST_MISS      = 3'd3;
    localparam logic [2:0] ST_GAME_OVER = 3'd4;

    // Cycle counts are formed in 64 bits because SERVE_MS*CLK_HZ overflows 32 bits.
    localparam logic [63:0] PSC64   = 64'(CLK_HZ / SPEED);
    localparam logic [63:0] SERVE64 = (64'(SERVE_MS) * 64'(CLK_HZ)) / 64'd1000;
    localparam logic [63:0] MISS64  = (64'(MISS_MS) * 64'(CLK_HZ)) / 64'd1000;
    localparam logic [31:0] TICK_LAST  = (PSC64 > 64'd1)   ? 32'(PSC64 - 64'd1)   : 32'd0;
    localparam logic [31:0] SERVE_LAST = (SERVE64 > 64'd1) ? 32'(SERVE64 - 64'd1) : 32'd0;
    localparam logic [31:0] MISS_LAST  = (MISS64 > 64'd1)  ? 32'(MISS64 - 64'd1)  : 32'd0;

    localparam logic [9:0]  X_CENTRE = 10'((H_VIDEO - SQ_WIDTH) / 2);
    localparam logic [9:0]  Y_CENTRE = 10'((V_VIDEO - SQ_WIDTH) / 2);
    localparam logic [9:0]  X_MAX    = 10'(H_VIDEO - SQ_WIDTH);
    localparam logic [9:0]  Y_MAX    = 10'(V_VIDEO - SQ_WIDTH);
    localparam logic [9:0]  P1_FACE  = 10'(P1_X + PDL_WIDTH);
    localparam logic [9:0]  P2_FACE  = 10'(P2_X - SQ_WIDTH);
    localparam logic [3:0]  WIN      = 4'(WIN_SCORE);

    logic [2:0]  state;
    logic [31:0] tick_cnt;
    logic [31:0] phase_cnt;
    logic [9:0]  x_pos;
    logic [9:0]  y_pos;
    logic        x_dir;
    logic        y_dir;
    logic        missed;
    logic        game_start;
    logic [3:0]  score1;
    logic [3:0]  score2;
    logic        over;

    logic [10:0] sq_bottom;
    logic        p1_hit;
    logic        p2_hit;
    logic        tick;
    logic [9:0]  x_next;
    logic [9:0]  y_next;
    logic        x_dir_next;
    logic        y_dir_next;
    logic        p1_scores;
    logic        p2_scores;

    assign sq_bottom = {1'b0, y_pos} + 11'(SQ_WIDTH);
    assign p1_hit    = (sq_bottom > {1'b0, bus.p1_ypos}) &&
                       ({1'b0, y_pos} < ({1'b0, bus.p1_ypos} + 11'(PDL_HEIGHT)));
    assign p2_hit    = (sq_bottom > {1'b0, bus.p2_ypos}) &&
                       ({1'b0, y_pos} < ({1'b0, bus.p2_ypos} + 11'(PDL_HEIGHT)));
    assign tick      = (state == ST_PLAY) && (tick_cnt == TICK_LAST);

    // One-pixel step per axis; the two axes are resolved independently so a corner flips both.
    always_comb begin
        y_next     = y_dir ? y_pos + 10'd1 : y_pos - 10'd1;
        y_dir_next = y_dir;
        if (!y_dir && y_pos == 10'd0) begin
            y_next     = 10'd1;
            y_dir_next = 1'b1;
        end else if (y_dir && y_pos == Y_MAX) begin
            y_next     = Y_MAX - 10'd1;
            y_dir_next = 1'b0;
        end

        x_next     = x_pos;
        x_dir_next = x_dir;
        p1_scores  = 1'b0;
        p2_scores  = 1'b0;
        if (!x_dir) begin
            if (x_pos == P1_FACE && p1_hit) begin
                x_next     = x_pos + 10'd1;
                x_dir_next = 1'b1;
            end else if (x_pos == 10'd0) begin
                p2_scores = 1'b1;
            end else begin
                x_next = x_pos - 10'd1;
            end
        end else begin
            if (x_pos == P2_FACE && p2_hit) begin
                x_next     = x_pos - 10'd1;
                x_dir_next = 1'b0;
            end else if (x_pos == X_MAX) begin
                p1_scores = 1'b1;
            end else begin
                x_next = x_pos + 10'd1;
            end
        end
    end

    always_ff @(posedge clk_0) begin
        if (rst) begin
            state      <= ST_IDLE;
            tick_cnt   <= 32'd0;
            phase_cnt  <= 32'd0;
            x_pos      <= X_CENTRE;
            y_pos      <= Y_CENTRE;
            x_dir      <= 1'b1;
            y_dir      <= 1'b0;
            missed     <= 1'b0;
            game_start <= 1'b0;
            score1     <= 4'd0;
            score2     <= 4'd0;
            over       <= 1'b0;
        end else begin
            game_start <= 1'b0;
            case (state)
                ST_IDLE, ST_GAME_OVER: begin
                    if (bus.start) begin
                        game_start <= 1'b1;
                        score1     <= 4'd0;
                        score2     <= 4'd0;
                        over       <= 1'b0;
                        x_pos      <= X_CENTRE;
                        y_pos      <= Y_CENTRE;
                        x_dir      <= 1'b1;
                        y_dir      <= ~y_dir;
                        phase_cnt  <= 32'd0;
                        state      <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (phase_cnt == SERVE_LAST) begin
                        phase_cnt <= 32'd0;
                        tick_cnt  <= 32'd0;
                        state     <= ST_PLAY;
                    end else begin
                        phase_cnt <= phase_cnt + 32'd1;
                    end
                end
                ST_PLAY: begin
                    if (tick) begin
                        tick_cnt <= 32'd0;
                        x_pos    <= x_next;
                        y_pos    <= y_next;
                        x_dir    <= x_dir_next;
                        y_dir    <= y_dir_next;
                        if (p1_scores || p2_scores) begin
                            missed    <= 1'b1;
                            phase_cnt <= 32'd0;
                            state     <= ST_MISS;
                        end
                        if (p1_scores && score1 < WIN) score1 <= score1 + 4'd1;
                        if (p2_scores && score2 < WIN) score2 <= score2 + 4'd1;
                    end else begin
                        tick_cnt <= tick_cnt + 32'd1;
                    end
                end
                ST_MISS: begin
                    if (phase_cnt == MISS_LAST) begin
                        // The serve keeps the miss direction, i.e. it heads toward whoever conceded.
                        phase_cnt <= 32'd0;
                        missed    <= 1'b0;
                        x_pos     <= X_CENTRE;
                        y_pos     <= Y_CENTRE;
                        if (score1 == WIN || score2 == WIN) begin
                            over  <= 1'b1;
                            state <= ST_GAME_OVER;
                        end else begin
                            y_dir <= ~y_dir;
                            state <= ST_SERVE;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 32'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.sq_xpos    = x_pos;
    assign bus.sq_ypos    = y_pos;
    assign bus.sq_xveldir = x_dir;
    assign bus.sq_yveldir = y_dir;
    assign bus.sq_missed  = missed;
    assign bus.reset_game = game_start;
    assign bus.score_p1   = score1;
    assign bus.score_p2   = score2;
    assign bus.game_over  = over;
endmodule
